// File: rtl/mm_result_drain.sv
// rtl/mm_result_drain.sv - snapshots the 8x8 matmul result, requantizes to int8 and streams it row by row
// Optional ReLU before rounding: define MM_DRAIN_RELU_EN.
module mm_result_drain #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  res [0:7][0:7],
    input  logic                    capture,
    output logic                    capture_ready,
    input  logic [4:0]              shift_amt,
    output logic                    flush,
    output logic [8*OUT_W-1:0]      out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [2:0]              out_row
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic signed [IN_W:0] QMAX = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] QMIN = (IN_W+1)'(-(2**(OUT_W-1)));

    state_t                   state;
    state_t                   state_next;
    logic signed [IN_W-1:0]   snap [0:7][0:7];
    logic [4:0]               shift_q;
    logic                     accept;
    logic                     xfer;
    logic [2:0]               src_row;
    logic [4:0]               q_shift;
    logic [8*OUT_W-1:0]       q_row;

    // Rounding add is done one bit wider so x near +max cannot wrap.
    function automatic logic [OUT_W-1:0] quant(input logic signed [IN_W-1:0] x, input logic [4:0] s);
        logic signed [IN_W:0] v;
        logic signed [IN_W:0] rnd;
        logic signed [IN_W:0] y;
        v = {x[IN_W-1], x};
`ifdef MM_DRAIN_RELU_EN
        if (x[IN_W-1]) v = '0;
`endif
        rnd = '0;
        if (s != 5'd0) rnd = (IN_W+1)'(1) << (s - 5'd1);
        y = (s == 5'd0) ? v : ((v + rnd) >>> s);
        if (y > QMAX)      return QMAX[OUT_W-1:0];
        else if (y < QMIN) return QMIN[OUT_W-1:0];
        else               return y[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = SEND;
            SEND:    if (out_ready && out_row == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture_ready = (state == IDLE);
        out_valid     = (state == SEND);
        out_last      = out_valid && (out_row == 3'd7);
        accept        = capture_ready && capture;
        xfer          = out_valid && out_ready;
    end

    // Row 0 is quantized straight from res on capture; later rows come from the snapshot.
    assign src_row = out_row + 3'd1;
    assign q_shift = capture_ready ? shift_amt : shift_q;

    for (genvar j = 0; j < 8; j++) begin : g_quant
        assign q_row[(8-j)*OUT_W-1 -: OUT_W] = quant(capture_ready ? res[0][j] : snap[src_row][j], q_shift);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            snap    <= res;
            shift_q <= shift_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush    <= 1'b0;
            out_data <= '0;
            out_row  <= '0;
        end else begin
            flush <= accept;
            if (accept) begin
                out_data <= q_row;
                out_row  <= '0;
            end else if (xfer) begin
                if (out_row == 3'd7) begin
                    out_row <= '0;
                end else begin
                    out_row  <= out_row + 3'd1;
                    out_data <= q_row;
                end
            end
        end
    end

endmodule
